// File: rtl/sb_alloc_ctrl.sv
// rtl/sb_alloc_ctrl.sv - in-order transaction ID allocator with out-of-order writeback tracking
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   flush_i                    drop every in-flight transaction
//   alloc_req_i / alloc_gnt_o  issue-side ID request / acceptance
//   alloc_id_o                 ID handed out on a grant (always the tail)
//   wb_valid_i, wb_id_i,       per-port writeback strobe, ID and exception flag;
//   wb_ex_i                    port p uses wb_id_i[p*ID_BITS +: ID_BITS]
//   commit_valid_o, commit_id_o, commit_ex_o
//                              oldest transaction is done / its ID / its exception
//   commit_ack_i               retire the oldest transaction
//   full_o, empty_o, count_o   occupancy status

module sb_alloc_ctrl #(
    parameter int NR_ENTRIES  = 4,
    parameter int NR_WB_PORTS = 4,
    parameter int ID_BITS     = $clog2(NR_ENTRIES)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           alloc_req_i,
    output logic                           alloc_gnt_o,
    output logic [ID_BITS-1:0]             alloc_id_o,
    input  logic [NR_WB_PORTS-1:0]         wb_valid_i,
    input  logic [NR_WB_PORTS*ID_BITS-1:0] wb_id_i,
    input  logic [NR_WB_PORTS-1:0]         wb_ex_i,
    output logic                           commit_valid_o,
    output logic [ID_BITS-1:0]             commit_id_o,
    output logic                           commit_ex_o,
    input  logic                           commit_ack_i,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [ID_BITS:0]               count_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_DONE   = 2'd2
    } entry_state_e;

    entry_state_e            state_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]   ex_q;
    logic [ID_BITS-1:0]      head_q;
    logic [ID_BITS-1:0]      tail_q;
    logic [ID_BITS:0]        count_q;

    logic [NR_ENTRIES-1:0]   wb_hit;
    logic [NR_ENTRIES-1:0]   wb_ex_any;
    logic                    grant;
    logic                    commit;

    assign full_o  = (count_q == (ID_BITS+1)'(NR_ENTRIES));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Full is judged on the registered count only, so a same-cycle commit
    // never opens a slot. Gating with rst_ni keeps the grant low while the
    // block is held in reset even if the issue stage is requesting.
    assign grant       = alloc_req_i & ~full_o & ~flush_i & rst_ni;
    assign alloc_gnt_o = grant;
    assign alloc_id_o  = tail_q;

    assign commit_valid_o = (state_q[head_q] == ST_DONE);
    assign commit_id_o    = head_q;
    assign commit_ex_o    = ex_q[head_q];
    assign commit            = commit_valid_o & commit_ack_i;

    // Collapse all writeback ports into per-entry hit and merged-exception
    // vectors so several ports naming the same ID combine naturally.
    always_comb begin
        wb_hit    = '0;
        wb_ex_any = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && (wb_id_i[p*ID_BITS +: ID_BITS] == ID_BITS'(e))) begin
                    wb_hit[e]    = 1'b1;
                    wb_ex_any[e] = wb_ex_any[e] | wb_ex_i[p];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                state_q[e] <= ST_FREE;
            end
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            for (int e = 0; e < NR_ENTRIES; e++) begin
                state_q[e] <= ST_FREE;
            end
            ex_q    <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Writebacks only land on ISSUED entries; FREE and DONE are left alone.
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (wb_hit[e] && (state_q[e] == ST_ISSUED)) begin
                    state_q[e] <= ST_DONE;
                    ex_q[e]    <= ex_q[e] | wb_ex_any[e];
                end
            end
            // Head is DONE so no writeback touches it; tail is FREE when a
            // grant happens, so these updates never collide with the loop above.
            if (commit) begin
                state_q[head_q] <= ST_FREE;
                ex_q[head_q]    <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (grant) begin
                state_q[tail_q] <= ST_ISSUED;
                ex_q[tail_q]    <= 1'b0;
                tail_q          <= tail_q + 1'b1;
            end
            if (grant && !commit) begin
                count_q <= count_q + 1'b1;
            end else if (commit && !grant) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sb_alloc_ctrl.sv
// tb/tb_sb_alloc_ctrl.sv - self-checking bench for sb_alloc_ctrl
module tb_sb_alloc_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       alloc_req_i;
    logic       alloc_gnt_o;
    logic [1:0] alloc_id_o;
    logic [3:0] wb_valid_i;
    logic [7:0] wb_id_i;
    logic [3:0] wb_ex_i;
    logic       commit_valid_o;
    logic [1:0] commit_id_o;
    logic       commit_ex_o;
    logic       commit_ack_i;
    logic       full_o;
    logic       empty_o;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;

    sb_alloc_ctrl #(
        .NR_ENTRIES  (4),
        .NR_WB_PORTS (4),
        .ID_BITS     (2)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .alloc_req_i    (alloc_req_i),
        .alloc_gnt_o    (alloc_gnt_o),
        .alloc_id_o     (alloc_id_o),
        .wb_valid_i     (wb_valid_i),
        .wb_id_i        (wb_id_i),
        .wb_ex_i        (wb_ex_i),
        .commit_valid_o (commit_valid_o),
        .commit_id_o    (commit_id_o),
        .commit_ex_o    (commit_ex_o),
        .commit_ack_i   (commit_ack_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       fl;
        logic       rq;
        logic [3:0] wbv;
        logic [7:0] wbid;
        logic [3:0] wbex;
        logic       ack;
        logic       g;
        logic [1:0] aid;
        logic       cv;
        logic [1:0] cid;
        logic       cex;
        logic       fu;
        logic       em;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs [64];
    int   nvec = 0;

    task automatic add(input logic fl, input logic rq, input logic [3:0] wbv,
                       input logic [7:0] wbid, input logic [3:0] wbex, input logic ack,
                       input logic g, input logic [1:0] aid, input logic cv,
                       input logic [1:0] cid, input logic cex, input logic fu,
                       input logic em, input logic [2:0] cnt);
        vecs[nvec] = '{fl, rq, wbv, wbid, wbex, ack, g, aid, cv, cid, cex, fu, em, cnt};
        nvec++;
    endtask

    task automatic check_outs(input string name, input logic g, input logic [1:0] aid,
                              input logic cv, input logic [1:0] cid, input logic cex,
                              input logic fu, input logic em, input logic [2:0] cnt);
        logic [11:0] got;
        logic [11:0] exp;
        got = {alloc_gnt_o, alloc_id_o, commit_valid_o, commit_id_o, commit_ex_o,
               full_o, empty_o, count_o};
        exp = {g, aid, cv, cid, cex, fu, em, cnt};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d cv=%b cid=%0d cex=%b full=%b empty=%b cnt=%0d, want gnt=%b id=%0d cv=%b cid=%0d cex=%b full=%b empty=%b cnt=%0d",
                     name, alloc_gnt_o, alloc_id_o, commit_valid_o, commit_id_o, commit_ex_o,
                     full_o, empty_o, count_o, g, aid, cv, cid, cex, fu, em, cnt);
        end
    endtask

    task automatic idle_inputs();
        flush_i      = 1'b0;
        alloc_req_i  = 1'b0;
        wb_valid_i   = '0;
        wb_id_i      = '0;
        wb_ex_i      = '0;
        commit_ack_i = 1'b0;
    endtask

    initial begin
        //   fl rq wbv      wbid         wbex     ack  g aid cv cid cex fu em cnt
        // fill: four grants, then full and no fifth grant
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 2, 0, 0, 0, 0, 0, 2);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 3, 0, 0, 0, 0, 0, 3);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   0, 0, 0, 0, 0, 1, 0, 4);
        // out-of-order writeback: ID 2 then ID 0
        add(0, 0, 4'b0001, 8'h02,       4'b0000, 0,   0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 4'b0001, 8'h00,       4'b0000, 0,   0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 0, 1, 0, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 1,   0, 0, 1, 0, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 0, 0, 1, 0, 0, 0, 3);
        // ack with nothing ready is ignored
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 1,   0, 0, 0, 1, 0, 0, 0, 3);
        // exception merge: ID 1 on port 0 (ex=0) and port 3 (ex=1)
        add(0, 0, 4'b1001, 8'b01000001, 4'b1000, 0,   0, 0, 0, 1, 0, 0, 0, 3);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 0, 1, 1, 1, 0, 0, 3);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 1,   0, 0, 1, 1, 1, 0, 0, 3);
        // refill around the wrap, then full with ack+req: no grant
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 0, 1, 2, 0, 0, 0, 2);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 1, 1, 2, 0, 0, 0, 3);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 1,   0, 2, 1, 2, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 2, 0, 3, 0, 0, 0, 3);
        // flush with 3 issued plus same-cycle request and writeback
        add(1, 1, 4'b0001, 8'h03,       4'b0000, 0,   0, 2, 0, 3, 0, 0, 0, 3);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        // stale writebacks of IDs 0 and 1 after flush are ignored
        add(0, 0, 4'b0110, 8'b00010000, 4'b0000, 0,   0, 0, 0, 0, 0, 0, 1, 0);
        // fresh fill, then full + head DONE + ack + req
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 2, 0, 0, 0, 0, 0, 2);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 3, 0, 0, 0, 0, 0, 3);
        add(0, 0, 4'b0010, 8'h00,       4'b0000, 0,   0, 0, 0, 0, 0, 1, 0, 4);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 1,   0, 0, 1, 0, 0, 1, 0, 4);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 0, 0, 1, 0, 0, 0, 3);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 1, 0, 1, 0, 1, 0, 4);
        // writeback to an already DONE entry must not set its exception
        add(0, 0, 4'b0001, 8'h01,       4'b0000, 0,   0, 1, 0, 1, 0, 1, 0, 4);
        add(0, 0, 4'b0100, 8'b00010000, 4'b0100, 0,   0, 1, 1, 1, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 1,   0, 1, 1, 1, 0, 1, 0, 4);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 0,   1, 1, 0, 2, 0, 0, 0, 3);
        add(0, 0, 4'b1000, 8'b10000000, 4'b0000, 0,   0, 2, 0, 2, 0, 1, 0, 4);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 1,   0, 2, 1, 2, 0, 1, 0, 4);
        // grant and commit together when not full: count unchanged
        add(0, 0, 4'b0001, 8'h03,       4'b0000, 0,   0, 2, 0, 3, 0, 0, 0, 3);
        add(0, 1, 4'b0000, 8'h00,       4'b0000, 1,   1, 2, 1, 3, 0, 0, 0, 3);
        add(0, 0, 4'b0000, 8'h00,       4'b0000, 0,   0, 3, 0, 0, 0, 0, 0, 3);

        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        alloc_req_i = 1'b1;
        #2;
        check_outs("reset_outputs", 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        alloc_req_i = 1'b0;
        rst_ni = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk_i);
            flush_i      = vecs[i].fl;
            alloc_req_i  = vecs[i].rq;
            wb_valid_i   = vecs[i].wbv;
            wb_id_i      = vecs[i].wbid;
            wb_ex_i      = vecs[i].wbex;
            commit_ack_i = vecs[i].ack;
            #2;
            check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].aid, vecs[i].cv,
                       vecs[i].cid, vecs[i].cex, vecs[i].fu, vecs[i].em, vecs[i].cnt);
        end

        // Reset mid-operation (3 in flight): asynchronous clear, then first grant is ID 0
        @(negedge clk_i);
        idle_inputs();
        alloc_req_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check_outs("midop_reset_async", 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #2;
        check_outs("first_grant_after_reset", 1, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk_i);
        alloc_req_i = 1'b0;
        #2;
        check_outs("after_first_grant", 0, 1, 0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_alloc_ctrl.md
SB_ALLOC_CTRL -- requirements
Module: sb_alloc_ctrl

Interface
REQ-001 Parameter NR_ENTRIES, default 4: number of in-flight transactions; power of two, at least 2.
REQ-002 Parameter NR_WB_PORTS, default 4: number of writeback ports.
REQ-003 Parameter ID_BITS, default $clog2(NR_ENTRIES): transaction-ID width.
REQ-004 Port clk_i  in  1: the single clock; all state on rising edge.
REQ-005 Port rst_ni  in  1: reset, asynchronous, active-low.
REQ-006 Port flush_i  in  1: discard all in-flight transactions.
REQ-007 Port alloc_req_i  in  1: issue stage requests a transaction ID.
REQ-008 Port alloc_gnt_o  out  1: request accepted this cycle.
REQ-009 Port alloc_id_o  out  ID_BITS: ID assigned to the accepted request.
REQ-010 Port wb_valid_i  in  NR_WB_PORTS: per-port writeback strobe.
REQ-011 Port wb_id_i  in  NR_WB_PORTS*ID_BITS: per-port writeback ID; port p occupies bits [p*ID_BITS +: ID_BITS].
REQ-012 Port wb_ex_i  in  NR_WB_PORTS: per-port writeback carries an exception.
REQ-013 Port commit_valid_o  out  1: oldest transaction is done and ready to commit.
REQ-014 Port commit_id_o  out  ID_BITS: ID of the oldest transaction.
REQ-015 Port commit_ex_o  out  1: oldest transaction carries an exception.
REQ-016 Port commit_ack_i  in  1: commit stage retires the oldest transaction.
REQ-017 Port full_o  out  1: all entries in use.
REQ-018 Port empty_o  out  1: no entries in use.
REQ-019 Port count_o  out  ID_BITS+1: number of entries in use, 0..NR_ENTRIES.

Function
REQ-020 Each entry SHALL hold a registered state FREE, ISSUED or DONE, plus an exception flag.
REQ-021 The block SHALL keep a head pointer (oldest) and a tail pointer (next to allocate), both ID_BITS wide, wrapping modulo NR_ENTRIES, plus an occupancy counter.
REQ-022 alloc_gnt_o SHALL equal alloc_req_i & ~full_o & ~flush_i, combinationally, based on the current-cycle full_o only; a same-cycle commit SHALL NOT free a slot for allocation.
REQ-023 alloc_id_o SHALL equal the tail pointer at all times; on a grant the tail entry SHALL become ISSUED with the exception flag cleared, and tail SHALL increment, both at the next edge.
REQ-024 A writeback on any port whose ID targets an ISSUED entry SHALL set that entry to DONE at the next edge and SHALL OR wb_ex_i into its exception flag.
REQ-025 A writeback to a FREE or DONE entry SHALL be ignored without changing state.
REQ-026 Multiple ports writing back the same ID in one cycle SHALL produce DONE, with the exception flag set to the OR of all those ports.
REQ-027 commit_valid_o SHALL be 1 if and only if the head entry is DONE (registered state); writeback-to-commit latency SHALL be exactly 1 cycle.
REQ-028 commit_id_o SHALL equal head; commit_ex_o SHALL equal the head entry's exception flag.
REQ-029 commit_ack_i & commit_valid_o SHALL free the head entry and increment head at the next edge; commit_ack_i while commit_valid_o=0 SHALL be ignored.
REQ-030 The counter SHALL change by +1 on grant only, -1 on commit only, and stay unchanged when both occur; full_o = (count==NR_ENTRIES), empty_o = (count==0).
REQ-031 flush_i SHALL, at the next edge, set all entries FREE, clear all exception flags, and zero head, tail and count; flush takes priority over same-cycle grant, writeback and commit.
REQ-032 Only the oldest transaction may commit; commits SHALL occur strictly in allocation order.

Reset
REQ-033 When rst_ni is low, the block SHALL asynchronously set all entries FREE with exception flags clear and head, tail and count to 0.
REQ-034 During reset, outputs SHALL be: alloc_gnt_o=0, alloc_id_o=0, commit_valid_o=0, commit_id_o=0, commit_ex_o=0, full_o=0, empty_o=1, count_o=0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight state; the first grant after release SHALL return ID 0.

Verification
REQ-036 Fill: hold alloc_req_i for 5 cycles after reset -> grants with IDs 0,1,2,3, then full_o=1, count_o=4 and no fifth grant.
REQ-037 Out-of-order writeback: with IDs 0-2 issued, write back ID 2 then ID 0 -> commit_valid_o=1 with ID 0 one cycle after ID 0's writeback; after ack, commit_valid_o=0 until ID 1 is written back.
REQ-038 Exception merge: write back ID 1 on port 0 (ex=0) and port 3 (ex=1) in the same cycle -> the later commit of ID 1 shows commit_ex_o=1.
REQ-039 Full with simultaneous ack and request: full, head DONE, commit_ack_i=1 and alloc_req_i=1 -> no grant that cycle, count_o=3 next cycle, grant of ID 0 (wrap-around) the following cycle.
REQ-040 Flush: flush_i=1 with 3 entries issued and a same-cycle request and writeback -> no grant; next cycle empty_o=1, count_o=0, alloc_id_o=0; a stale writeback of ID 1 afterwards is ignored.
